// File: rtl/label_scanner_pkg.sv
// Shared constants, state encoding and LB word decode for the label scanner.
// The CLEAR state exists only when LBSCAN_CLEAR_EN is defined.
package label_scanner_pkg;

  localparam int LBID_W = 12;
  localparam int TYPE_W = 6;

  localparam logic [5:0] OP_LB = 6'h2C;

  localparam logic [TYPE_W-1:0] LBTYPE_CODE  = 6'h01;
  localparam logic [TYPE_W-1:0] LBTYPE_DATA  = 6'h02;
  localparam logic [TYPE_W-1:0] LBTYPE_UNDEF = 6'h3F;

  localparam int LB_OP_HI = 31;
  localparam int LB_OP_LO = 26;
  localparam int LB_ID_HI = 25;
  localparam int LB_ID_LO = 14;
  localparam int LB_TY_HI = 13;
  localparam int LB_TY_LO = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EMIT   = 3'd4,
    ST_FINAL  = 3'd5,
    ST_DONE   = 3'd6
`ifdef LBSCAN_CLEAR_EN
    ,
    ST_CLEAR  = 3'd7
`endif
  } state_e;

  typedef struct packed {
    logic              is_lb;
    logic [LBID_W-1:0] lbid;
    logic [TYPE_W-1:0] ltype;
  } lb_t;

  function automatic lb_t lb_decode(input logic [31:0] w);
    lb_t r;
    r.is_lb = (w[LB_OP_HI:LB_OP_LO] == OP_LB);
    r.lbid  = w[LB_ID_HI:LB_ID_LO];
    r.ltype = w[LB_TY_HI:LB_TY_LO];
    return r;
  endfunction

endpackage

// File: rtl/label_scanner.sv
// Walks code memory once per program load and writes one label-table entry per LB word.
// Optional macro LBSCAN_CLEAR_EN: sweep every lbid to UNDEF before scanning.
module label_scanner
  import label_scanner_pkg::*;
#(
  parameter int LBID_LIMIT = 4096,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] codeLen,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRe,
  input  logic [31:0]       memData,
  output logic [LBID_W-1:0] lbidw,
  output logic [TYPE_W-1:0] lbTypew,
  output logic [ADDR_W-1:0] basew,
  output logic [ADDR_W-1:0] countw,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] LIMIT_U = LBID_LIMIT;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [31:0]         data_q, data_d;
  logic                pend_q, pend_d;
  logic [LBID_W-1:0]   pend_lbid_q, pend_lbid_d;
  logic [TYPE_W-1:0]   pend_type_q, pend_type_d;
  logic [ADDR_W-1:0]   pend_base_q, pend_base_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_re_q, mem_re_d;
  logic [LBID_W-1:0]   lbid_q, lbid_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef LBSCAN_CLEAR_EN
  localparam logic [LBID_W-1:0] CLR_LAST = LBID_W'(LBID_LIMIT - 1);
  logic [LBID_W-1:0]   clr_q, clr_d;
`endif

  lb_t               dec;
  logic [31:0]       lbid_ext;
  logic              in_range;
  logic [ADDR_W-1:0] addr_inc;
  logic              load_lb;
  logic              advance;

  assign dec      = lb_decode(data_q);
  assign lbid_ext = {{(32-LBID_W){1'b0}}, dec.lbid};
  assign in_range = (lbid_ext < LIMIT_U);
  assign addr_inc = addr_q + ADDR_W'(1);

  // Control and scan-state next values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    data_d      = data_q;
    pend_d      = pend_q;
    pend_lbid_d = pend_lbid_q;
    pend_type_d = pend_type_q;
    pend_base_d = pend_base_q;
    err_d       = err_q;
    load_lb     = 1'b0;
    advance     = 1'b0;
`ifdef LBSCAN_CLEAR_EN
    clr_d       = clr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d  = codeLen;
          addr_d = '0;
          err_d  = 1'b0;
          pend_d = 1'b0;
`ifdef LBSCAN_CLEAR_EN
          clr_d   = '0;
          state_d = ST_CLEAR;
`else
          state_d = (codeLen == '0) ? ST_FINAL : ST_FETCH;
`endif
        end
      end
`ifdef LBSCAN_CLEAR_EN
      ST_CLEAR: begin
        clr_d = clr_q + LBID_W'(1);
        if (clr_q == CLR_LAST) begin
          state_d = (len_q == '0) ? ST_FINAL : ST_FETCH;
        end
      end
`endif
      ST_FETCH:  state_d = ST_WAIT;
      ST_WAIT: begin
        data_d  = memData;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // A second label must first flush the pending one through EMIT.
        if (dec.is_lb && pend_q) begin
          state_d = ST_EMIT;
        end else begin
          load_lb = dec.is_lb;
          advance = 1'b1;
        end
      end
      ST_EMIT: begin
        load_lb = 1'b1;
        advance = 1'b1;
      end
      ST_FINAL:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (load_lb) begin
      if (in_range) begin
        pend_d      = 1'b1;
        pend_lbid_d = dec.lbid;
        pend_type_d = dec.ltype;
        pend_base_d = addr_q;
      end else begin
        pend_d = 1'b0;
        err_d  = 1'b1;
      end
    end

    if (advance) begin
      addr_d  = addr_inc;
      state_d = (addr_inc == len_q) ? ST_FINAL : ST_FETCH;
    end
  end

  // Outputs are registered from the state being entered, so they line up with that state.
  always_comb begin
    mem_re_d   = (state_d == ST_FETCH);
    mem_addr_d = (state_d == ST_FETCH) ? addr_d : mem_addr_q;
    we_d       = 1'b0;
    lbid_d     = lbid_q;
    type_d     = type_q;
    base_d     = base_q;
    count_d    = count_q;
    busy_d     = !((state_d == ST_IDLE) || (state_d == ST_DONE));
    done_d     = (state_d == ST_DONE);

    if (state_d == ST_EMIT) begin
      we_d    = 1'b1;
      lbid_d  = pend_lbid_d;
      type_d  = pend_type_d;
      base_d  = pend_base_d;
      count_d = addr_d - pend_base_d;
    end else if ((state_d == ST_FINAL) && pend_d) begin
      we_d    = 1'b1;
      lbid_d  = pend_lbid_d;
      type_d  = pend_type_d;
      base_d  = pend_base_d;
      count_d = len_d - pend_base_d;
    end
`ifdef LBSCAN_CLEAR_EN
    else if (state_d == ST_CLEAR) begin
      we_d    = 1'b1;
      lbid_d  = clr_d;
      type_d  = LBTYPE_UNDEF;
      base_d  = '0;
      count_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      pend_lbid_q <= '0;
      pend_type_q <= '0;
      pend_base_q <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      lbid_q      <= '0;
      type_q      <= '0;
      base_q      <= '0;
      count_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LBSCAN_CLEAR_EN
      clr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_lbid_q <= pend_lbid_d;
      pend_type_q <= pend_type_d;
      pend_base_q <= pend_base_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      lbid_q      <= lbid_d;
      type_q      <= type_d;
      base_q      <= base_d;
      count_q     <= count_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LBSCAN_CLEAR_EN
      clr_q       <= clr_d;
`endif
    end
  end

  assign memAddr = mem_addr_q;
  assign memRe   = mem_re_q;
  assign lbidw   = lbid_q;
  assign lbTypew = type_q;
  assign basew   = base_q;
  assign countw  = count_q;
  assign we      = we_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_label_scanner.sv
// Bench for label_scanner: directed and random code images checked against a label-list model.
module tb_label_scanner;
  import label_scanner_pkg::*;

  localparam int LIM = 16;
`ifdef LBSCAN_CLEAR_EN
  localparam int CLR_N = LIM;
`else
  localparam int CLR_N = 0;
`endif

  typedef struct packed {
    logic [11:0] lbid;
    logic [5:0]  ty;
    logic [15:0] base;
    logic [15:0] cnt;
  } wr_t;

  logic        clk, rst_n, start, memRe, we, busy, done, err;
  logic [15:0] codeLen, memAddr, basew, countw;
  logic [31:0] memData;
  logic [11:0] lbidw;
  logic [5:0]  lbTypew;

  logic [31:0] mem [0:63];
  wr_t         wr_q[$];
  wr_t         exp_q[$];
  wr_t         mon_w;
  bit          exp_err;
  bit          mon_en;
  int          re_cnt, done_cnt, first_re_wr;
  int          checks, errors;

  label_scanner #(.LBID_LIMIT(LIM), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .codeLen(codeLen),
    .memAddr(memAddr), .memRe(memRe), .memData(memData),
    .lbidw(lbidw), .lbTypew(lbTypew), .basew(basew), .countw(countw),
    .we(we), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous code memory: one cycle read latency.
  always @(posedge clk) if (memRe) memData <= mem[memAddr[5:0]];

  always @(negedge clk) begin
    if (mon_en) begin
      if (we) begin
        mon_w.lbid = lbidw; mon_w.ty = lbTypew; mon_w.base = basew; mon_w.cnt = countw;
        wr_q.push_back(mon_w);
      end
      if (memRe) begin
        re_cnt++;
        if (first_re_wr < 0) first_re_wr = wr_q.size();
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [31:0] nop_word();
    logic [5:0] op;
    op = 6'($urandom_range(0, 63));
    if (op == OP_LB) op = 6'h00;
    return {op, 26'($urandom)};
  endfunction

  function automatic logic [31:0] lb_word(input int id, input logic [5:0] ty);
    return {OP_LB, 12'(id), ty, 8'($urandom)};
  endfunction

  task automatic fill_nops();
    for (int i = 0; i < 64; i++) mem[i] = nop_word();
  endtask

  // Reference: every label spans from its LB to the next LB (any lbid) or the end of code.
  task automatic build_expected(input int len);
    wr_t e;
    bit  have;
    int  pbase;
    logic [31:0] w;
    exp_q.delete();
    exp_err = 1'b0;
    have = 1'b0;
    pbase = 0;
    e = '0;
    for (int i = 0; i < CLR_N; i++) begin
      e.lbid = 12'(i); e.ty = LBTYPE_UNDEF; e.base = 16'd0; e.cnt = 16'd0;
      exp_q.push_back(e);
    end
    for (int a = 0; a < len; a++) begin
      w = mem[a];
      if (w[31:26] == OP_LB) begin
        if (have) begin
          e.cnt = 16'(a - pbase);
          exp_q.push_back(e);
        end
        have = 1'b0;
        if (int'(w[25:14]) < LIM) begin
          have = 1'b1; pbase = a;
          e.lbid = w[25:14]; e.ty = w[13:8]; e.base = 16'(a);
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    if (have) begin
      e.cnt = 16'(len - pbase);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_and_check(input int len, input string name, input bit poke);
    bit got;
    int budget;
    int cyc;
    build_expected(len);
    wr_q.delete();
    re_cnt = 0; done_cnt = 0; first_re_wr = -1; mon_en = 1'b1;
    @(posedge clk); #1;
    codeLen = 16'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; codeLen = 16'($urandom);
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b err=%b, want busy=1 err=0", name, busy, err);
    end
    got = 1'b0; cyc = 0;
    budget = len * 6 + CLR_N + 20;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cyc = c;
      if (done) begin got = 1'b1; break; end
      if (poke && c == 4) start = 1'b1;
      if (poke && c == 5) start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, budget);
    end else if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b want 0", name, busy);
    end
    if (len == 0) begin
      checks++;
      if (cyc > 2) begin
        errors++;
        $display("FAIL %s empty_latency: done after %0d cycles, want <=3", name, cyc + 1);
      end
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got lbid=%0d ty=%h base=%0d cnt=%0d want lbid=%0d ty=%h base=%0d cnt=%0d",
                 name, i, wr_q[i].lbid, wr_q[i].ty, wr_q[i].base, wr_q[i].cnt,
                 exp_q[i].lbid, exp_q[i].ty, exp_q[i].base, exp_q[i].cnt);
      end
    end
    checks++;
    if (err !== exp_err || done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s status: err=%b done_pulses=%0d busy=%b want err=%b done_pulses=1 busy=0",
               name, err, done_cnt, busy, exp_err);
    end
    checks++;
    if (re_cnt != len || (len > 0 && first_re_wr != CLR_N)) begin
      errors++;
      $display("FAIL %s reads: memRe=%0d first_at_write=%0d want memRe=%0d first_at_write=%0d",
               name, re_cnt, first_re_wr, len, CLR_N);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({memAddr, memRe, we, lbidw, lbTypew, basew, countw, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: memAddr=%h memRe=%b we=%b lbidw=%h ty=%h base=%h cnt=%h busy=%b done=%b err=%b want all 0",
               memAddr, memRe, we, lbidw, lbTypew, basew, countw, busy, done, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_two_labels();
    fill_nops();
    mem[0] = lb_word(0, LBTYPE_CODE);
    mem[4] = lb_word(5, LBTYPE_CODE);
  endtask

  task automatic test_labels();
    load_two_labels();
    run_and_check(10, "two_labels", 1'b0);
  endtask

  task automatic test_no_labels();
    fill_nops();
    run_and_check(3, "no_labels", 1'b0);
  endtask

  task automatic test_empty();
    fill_nops();
    mem[0] = lb_word(3, LBTYPE_DATA);
    run_and_check(0, "empty", 1'b0);
  endtask

  task automatic test_out_of_range();
    fill_nops();
    mem[0] = lb_word(1, LBTYPE_DATA);
    mem[2] = lb_word(20, LBTYPE_CODE);
    run_and_check(5, "out_of_range", 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
  endtask

  task automatic test_back_to_back();
    fill_nops();
    mem[0] = lb_word(2, LBTYPE_CODE);
    mem[1] = lb_word(3, LBTYPE_DATA);
    mem[2] = lb_word(2, LBTYPE_DATA);
    run_and_check(3, "back_to_back", 1'b1);
  endtask

  task automatic test_reset_restart();
    bit found;
    load_two_labels();
    wr_q.delete();
    re_cnt = 0; done_cnt = 0; first_re_wr = -1; mon_en = 1'b1;
    @(posedge clk); #1;
    codeLen = 16'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (memRe && memAddr == 16'd3) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_scan: fetch of word 3 not seen");
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || we !== 1'b0 || memAddr !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan outputs: busy=%b we=%b memAddr=%0d done=%b want 0 0 0 0",
               busy, we, memAddr, done);
    end
    checks++;
    if (wr_q.size() != CLR_N) begin
      errors++;
      $display("FAIL reset_mid_scan partial: writes=%0d want %0d", wr_q.size(), CLR_N);
    end
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check(10, "restart", 1'b0);
  endtask

  task automatic test_random();
    int len;
    string nm;
    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(0, 40);
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 3) == 0)
          mem[i] = lb_word($urandom_range(0, LIM + 7), 6'($urandom));
        else
          mem[i] = nop_word();
      end
      nm = $sformatf("random%0d", it);
      run_and_check(len, nm, (len >= 2) && ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0;
    rst_n = 1'b1; start = 1'b0; codeLen = 16'd0; memData = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    #1 rst_n = 1'b0;
    test_reset();
    test_labels();
    test_no_labels();
    test_empty();
    test_out_of_range();
    test_back_to_back();
    test_reset_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/label_scanner.md
Name: label_scanner

Overview:
- Fills the label table after a program load: walks code memory from word 0 to codeLen-1 and finds LB (label-define) instructions.
- For each label it issues one label-table write (lbid, type, base, count) on the MMU's write port.
- It drives that port directly; the MMU lookup side consumes the result.
- Runs once per program load, before the CPU core is released.

Parameters:
- LBID_LIMIT, 4096: number of valid label ids. An LB with lbid >= LBID_LIMIT is an error and is not written.
- ADDR_W, 16: width of code addresses, base and count.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin scan; sampled only in IDLE.
- codeLen  in  16  number of code words; latched on start.
- memAddr  out  16  code memory read address.
- memRe  out  1  read enable; data returns on memData one cycle later.
- memData  in  32  code word.
- lbidw  out  12  label id to write.
- lbTypew  out  6  label type to write.
- basew  out  16  first word address of the label.
- countw  out  16  label length in words.
- we  out  1  label-table write strobe; exactly one cycle per entry.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the scan completes.
- err  out  1  sticky out-of-range-lbid flag; cleared on start.

Behaviour:
- Reset (async, rst_n=0): state IDLE. memAddr=0, memRe=0, we=0, lbidw=0, lbTypew=0, basew=0, countw=0, busy=0, done=0, err=0. Outputs clear immediately, without waiting for a clock edge.
- Reset asserted mid-scan aborts the scan. No partial entry is written.
- LB decode:
  - memData[31:26]==`OP_LB
  - lbid=memData[25:14]
  - type=memData[13:8]
  - other bits ignored
- FSM states: IDLE, FETCH, WAIT, DECODE, EMIT, FINAL, DONE.
- IDLE:
  - start=1 latches codeLen, sets addr=0, clears err and pend, sets busy=1.
  - Next state is FETCH, or FINAL if codeLen==0.
  - start is ignored in every state other than IDLE.
- FETCH: memRe=1, memAddr=addr. Next state WAIT.
- WAIT: memRe=0. memData is valid in this cycle and is registered. Next state DECODE.
- DECODE:
  - Non-LB word: addr=addr+1; next state FETCH, or FINAL if addr+1==codeLen.
  - LB word with pend=1: next state EMIT.
  - LB word with pend=0: load pending entry (if in range); advance as for a non-LB word.
- EMIT:
  - we=1, lbidw/lbTypew/basew = pending entry, countw = addr - pendBase (16-bit unsigned).
  - The same cycle loads the new LB as the pending entry and advances addr.
- Pending entry:
  - A new LB always terminates the previous label's count, even if the new LB is out of range.
  - Out-of-range LB: err=1 and pend=0, so it is never written.
  - In-range LB: pend=1, pendBase = its own address.
- FINAL: if pend=1, we=1 with countw = codeLen - pendBase. Next state DONE.
- DONE: done=1 for one cycle, busy=0. Next state IDLE.
- Outputs and timing:
  - Write fields are registered and valid in the same cycle as we.
  - Minimum throughput is 3 cycles per code word.
  - addr wraps modulo 2^16; codeLen=65535 is the maximum.
  - Duplicate lbids are written again; the last write wins.
  - No LB in code: no writes, done still pulses.

Optional Feature:
- Macro LBSCAN_CLEAR_EN.
- Defined:
  - After start, a CLEAR state runs before the first FETCH, sweeping lbid 0..LBID_LIMIT-1.
  - It issues one write per cycle with lbTypew=`LBTYPE_UNDEF, basew=0, countw=0, we=1.
  - This adds LBID_LIMIT cycles.
  - Stale labels read back as an invalid type.
- Undefined: the CLEAR state and its counter are absent; unwritten entries keep their prior contents.

Decomposition:
- `OP_LB, `LBTYPE_UNDEF, the LB field bit positions and the state encodings go in def.v next to the existing LBTYPE_* constants.
- No sub-module is needed. The LB field extraction may be a small combinational helper, lb_decode, which is optional.

Test Plan:
- Labels at 0 and 4: codeLen=10, LB(lbid=0,type=CODE) at 0, LB(lbid=5,type=CODE) at 4, other words nops -> writes (0,CODE,base 0,count 4), then (5,CODE,4,6); done pulses once; err=0.
- No labels: codeLen=3, no LB -> no we pulses, done pulses, busy low afterwards.
- Empty program: codeLen=0 -> no memRe, done within 3 cycles of start.
- Out-of-range lbid: LBID_LIMIT=16, LB(lbid=20) at 2 after LB(lbid=1) at 0, codeLen=5 -> write (1,…,0,2) only; err=1 and stays 1 until the next start.
- Reset and restart: rst_n pulled low during WAIT of word 3 -> we/busy go 0 at once; restarting with the same image gives the same writes as a clean run.
- LBSCAN_CLEAR_EN, LBID_LIMIT=8: 8 consecutive UNDEF writes for lbid 0..7 precede the first memRe.
